// File: rtl/mult_18x18_pkg.sv
// Shared constants, Booth digit encoding and carry-save helper for the
// 5-stage 18x18 signed/unsigned multiplier.
package mult_18x18_pkg;
  localparam int OP_W        = 18;
  localparam int PROD_W      = 36;
  localparam int PIPE_STAGES = 5;
  localparam int PP_NUM      = 10;
  localparam int A_EXT_W     = OP_W + 1;
  localparam int B_EXT_W     = OP_W + 2;
  localparam int PP_W        = OP_W + 2;

  typedef enum logic [2:0] {
    BOOTH_ZERO = 3'd0,
    BOOTH_P1   = 3'd1,
    BOOTH_P2   = 3'd2,
    BOOTH_M1   = 3'd3,
    BOOTH_M2   = 3'd4
  } booth_digit_t;

  typedef struct packed {
    logic [PROD_W-1:0] sum;
    logic [PROD_W-1:0] carry;
  } csa_t;

  function automatic booth_digit_t booth_encode(input logic [2:0] win);
    booth_digit_t d;
    case (win)
      3'b001, 3'b010: d = BOOTH_P1;
      3'b011:         d = BOOTH_P2;
      3'b100:         d = BOOTH_M2;
      3'b101, 3'b110: d = BOOTH_M1;
      default:        d = BOOTH_ZERO;
    endcase
    return d;
  endfunction

  // 3:2 compressor across the full product width; the carry out of the MSB
  // is dropped because all arithmetic is modulo 2^PROD_W.
  function automatic csa_t csa3(input logic [PROD_W-1:0] x,
                                input logic [PROD_W-1:0] y,
                                input logic [PROD_W-1:0] z);
    csa_t              r;
    logic [PROD_W-1:0] maj;
    maj     = (x & y) | (x & z) | (y & z);
    r.sum   = x ^ y ^ z;
    r.carry = {maj[PROD_W-2:0], 1'b0};
    return r;
  endfunction
endpackage

// File: rtl/mult_18x18_booth_pp.sv
// One radix-4 Booth digit: decodes a 3-bit multiplier window and returns the
// selected multiple of the extended multiplicand, already negated when needed.
module mult_18x18_booth_pp
  import mult_18x18_pkg::*;
(
  input  logic        [2:0]         i_win,
  input  logic signed [A_EXT_W-1:0] i_a,
  output logic signed [PP_W-1:0]    o_pp
);
  booth_digit_t           digit;
  logic signed [PP_W-1:0] a_x1;
  logic signed [PP_W-1:0] a_x2;

  always_comb begin
    digit = booth_encode(i_win);
    a_x1  = {i_a[A_EXT_W-1], i_a};
    a_x2  = {i_a, 1'b0};
    case (digit)
      BOOTH_P1: o_pp = a_x1;
      BOOTH_P2: o_pp = a_x2;
      BOOTH_M1: o_pp = -a_x1;
      BOOTH_M2: o_pp = -a_x2;
      default:  o_pp = '0;
    endcase
  end
endmodule

// File: rtl/mult_18x18.sv
// 18x18 multiplier with per-operand signedness: radix-4 Booth recoding,
// carry-save reduction and a final adder spread over five register stages.
module mult_18x18
  import mult_18x18_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [OP_W-1:0]   i_multa,
  input  logic [OP_W-1:0]   i_multb,
  input  logic              i_multa_ns,
  input  logic              i_multb_ns,
  output logic [PROD_W-1:0] o_product
);
  // Stage p0: operand and format capture
  logic [OP_W-1:0] a_p0_d, a_p0_q;
  logic [OP_W-1:0] b_p0_d, b_p0_q;
  logic            a_ns_p0_d, a_ns_p0_q;
  logic            b_ns_p0_d, b_ns_p0_q;

  always_comb begin
    a_p0_d    = i_multa;
    b_p0_d    = i_multb;
    a_ns_p0_d = i_multa_ns;
    b_ns_p0_d = i_multb_ns;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      a_p0_q    <= '0;
      b_p0_q    <= '0;
      a_ns_p0_q <= 1'b0;
      b_ns_p0_q <= 1'b0;
    end else begin
      a_p0_q    <= a_p0_d;
      b_p0_q    <= b_p0_d;
      a_ns_p0_q <= a_ns_p0_d;
      b_ns_p0_q <= b_ns_p0_d;
    end
  end

  // Stage p1: sign/zero extension, Booth recoding, aligned partial products
  logic signed [A_EXT_W-1:0] a_ext;
  logic signed [B_EXT_W-1:0] b_ext;
  logic        [B_EXT_W:0]   b_win;
  logic signed [PP_W-1:0]    pp_raw  [PP_NUM];
  logic        [PROD_W-1:0]  pp_p1_d [PP_NUM];
  logic        [PROD_W-1:0]  pp_p1_q [PP_NUM];

  always_comb begin
    a_ext = {a_ns_p0_q & a_p0_q[OP_W-1], a_p0_q};
    b_ext = {{2{b_ns_p0_q & b_p0_q[OP_W-1]}}, b_p0_q};
    b_win = {b_ext, 1'b0};
  end

  for (genvar g = 0; g < PP_NUM; g++) begin : g_pp
    mult_18x18_booth_pp u_booth_pp (
      .i_win (b_win[2*g+2 -: 3]),
      .i_a   (a_ext),
      .o_pp  (pp_raw[g])
    );
  end

  always_comb begin
    for (int i = 0; i < PP_NUM; i++) begin
      pp_p1_d[i] = {{(PROD_W-PP_W){pp_raw[i][PP_W-1]}}, pp_raw[i]} << (2*i);
    end
  end

  always_ff @(posedge i_clk) begin
    for (int i = 0; i < PP_NUM; i++) begin
      if (i_rst) pp_p1_q[i] <= '0;
      else       pp_p1_q[i] <= pp_p1_d[i];
    end
  end

  // Stage p2: two carry-save levels, 10 rows -> 7 -> 5
  csa_t              l1 [3];
  csa_t              l2 [2];
  logic [PROD_W-1:0] tree_p2_d [5];
  logic [PROD_W-1:0] tree_p2_q [5];

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      l1[i] = csa3(pp_p1_q[3*i], pp_p1_q[3*i+1], pp_p1_q[3*i+2]);
    end
    l2[0] = csa3(l1[0].sum, l1[0].carry, l1[1].sum);
    l2[1] = csa3(l1[1].carry, l1[2].sum, l1[2].carry);
    tree_p2_d[0] = l2[0].sum;
    tree_p2_d[1] = l2[0].carry;
    tree_p2_d[2] = l2[1].sum;
    tree_p2_d[3] = l2[1].carry;
    tree_p2_d[4] = pp_p1_q[PP_NUM-1];
  end

  always_ff @(posedge i_clk) begin
    for (int i = 0; i < 5; i++) begin
      if (i_rst) tree_p2_q[i] <= '0;
      else       tree_p2_q[i] <= tree_p2_d[i];
    end
  end

  // Stage p3: three more carry-save levels, 5 rows -> 4 -> 3 -> 2
  csa_t              l3, l4, l5;
  logic [PROD_W-1:0] sum_p3_d, sum_p3_q;
  logic [PROD_W-1:0] carry_p3_d, carry_p3_q;

  always_comb begin
    l3         = csa3(tree_p2_q[0], tree_p2_q[1], tree_p2_q[2]);
    l4         = csa3(l3.sum, l3.carry, tree_p2_q[3]);
    l5         = csa3(l4.sum, l4.carry, tree_p2_q[4]);
    sum_p3_d   = l5.sum;
    carry_p3_d = l5.carry;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sum_p3_q   <= '0;
      carry_p3_q <= '0;
    end else begin
      sum_p3_q   <= sum_p3_d;
      carry_p3_q <= carry_p3_d;
    end
  end

  // Stage p4: carry-propagate adder into the output register
  logic [PROD_W-1:0] product_p4_d, product_p4_q;

  always_comb begin
    product_p4_d = sum_p3_q + carry_p3_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) product_p4_q <= '0;
    else       product_p4_q <= product_p4_d;
  end

  assign o_product = product_p4_q;
endmodule

// File: tb/tb_mult_18x18.sv
// Self-checking bench for mult_18x18: directed corner vectors plus a random
// stream compared every cycle against an arithmetic model delayed by 5 edges.
module tb_mult_18x18;
  logic        clk;
  logic        rst;
  logic [17:0] multa, multb;
  logic        multa_ns, multb_ns;
  logic [35:0] product;

  int          pass_cnt  = 0;
  int          total_cnt = 0;
  bit          chk_en    = 1'b0;

  mult_18x18 dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_multa    (multa),
    .i_multb    (multb),
    .i_multa_ns (multa_ns),
    .i_multb_ns (multb_ns),
    .o_product  (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [35:0] model_mul(input logic [17:0] a, input logic [17:0] b,
                                            input logic ans, input logic bns);
    longint sa, sb, p;
    sa = longint'(a);
    sb = longint'(b);
    if (ans && a[17]) sa = sa - 262144;
    if (bns && b[17]) sb = sb - 262144;
    p = sa * sb;
    return p[35:0];
  endfunction

  task automatic check_val(input string name, input logic [35:0] got, input logic [35:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%09h, expected 0x%09h", name, got, exp);
  endtask

  // Model: output after edge n is the product sampled at edge n-4, or zero if
  // reset was seen at any edge from n-4 through n.
  logic [35:0] prod_h [8];
  bit          rst_h  [8] = '{default: 1'b1};
  logic [35:0] exp_out = '0;
  int          cyc = 8;

  always @(posedge clk) begin
    bit any_rst;
    cyc++;
    rst_h[cyc & 7]  = rst;
    prod_h[cyc & 7] = model_mul(multa, multb, multa_ns, multb_ns);
    any_rst = 1'b0;
    for (int k = 0; k <= 4; k++) any_rst |= rst_h[(cyc - k) & 7];
    exp_out = any_rst ? 36'h0 : prod_h[(cyc - 4) & 7];
  end

  always @(negedge clk) begin
    if (chk_en) check_val("stream", product, exp_out);
  end

  task automatic run_vec(input logic [17:0] a, input logic [17:0] b, input logic ans,
                         input logic bns, input logic [35:0] expv, input string name);
    @(negedge clk);
    multa = a; multb = b; multa_ns = ans; multb_ns = bns;
    check_val({name, "_model"}, model_mul(a, b, ans, bns), expv);
    repeat (5) @(posedge clk);
    #1 check_val(name, product, expv);
  endtask

  task automatic drive_random();
    logic [17:0] corner [5];
    corner = '{18'h00000, 18'h00001, 18'h1FFFF, 18'h20000, 18'h3FFFF};
    multa    = ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 4)] : 18'($urandom_range(0, 262143));
    multb    = ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 4)] : 18'($urandom_range(0, 262143));
    multa_ns = 1'($urandom_range(0, 1));
    multb_ns = 1'($urandom_range(0, 1));
  endtask

  initial begin
    rst = 1'b1; multa = '0; multb = '0; multa_ns = 1'b0; multb_ns = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_val("reset_state", product, 36'h0);
    chk_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    run_vec(18'h3FFFF, 18'h3FFFF, 1'b0, 1'b0, 36'hFFFF80001, "unsigned_max");
    run_vec(18'h3FFFF, 18'h3FFFF, 1'b1, 1'b1, 36'h000000001, "signed_m1_m1");
    run_vec(18'h20000, 18'h20000, 1'b1, 1'b1, 36'h400000000, "signed_min_min");
    run_vec(18'h20000, 18'h1FFFF, 1'b1, 1'b1, 36'hC00020000, "signed_min_max");
    run_vec(18'h3FFFF, 18'h3FFFF, 1'b1, 1'b0, 36'hFFFFC0001, "mixed_sa_ub");
    run_vec(18'h3FFFF, 18'h3FFFF, 1'b0, 1'b1, 36'hFFFFC0001, "mixed_ua_sb");
    run_vec(18'h00000, 18'h2ABCD, 1'b0, 1'b0, 36'h000000000, "zero_unsigned");
    run_vec(18'h00000, 18'h3FFFF, 1'b1, 1'b1, 36'h000000000, "zero_signed");
    run_vec(18'h00001, 18'h2ABCD, 1'b0, 1'b0, 36'h00002ABCD, "ident_unsigned");
    run_vec(18'h00001, 18'h2ABCD, 1'b1, 1'b1, 36'hFFFFEABCD, "ident_signed");
    run_vec(18'h00003, 18'h3FFFE, 1'b0, 1'b1, 36'hFFFFFFFFA, "mixed_small");

    for (int n = 0; n < 30000; n++) begin
      if (n == 15000) begin
        @(negedge clk);
        rst = 1'b1;
        drive_random();
        @(posedge clk);
        #1 check_val("rst_edge", product, 36'h0);
        @(negedge clk);
        rst = 1'b0;
        multa = 18'h12345; multb = 18'h3FFFE; multa_ns = 1'b1; multb_ns = 1'b1;
        for (int j = 1; j <= 4; j++) begin
          @(posedge clk);
          #1 check_val($sformatf("rst_hold%0d", j), product, 36'h0);
        end
        @(posedge clk);
        #1 check_val("rst_resume", product, 36'hFFFFDB976);
      end else begin
        @(negedge clk);
        drive_random();
      end
    end

    repeat (6) @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
